// File: rtl/la_cmd_pkg.sv
// Shared opcodes, widths and FSM encoding for the logic analyzer host-link
// command decoder.
package la_cmd_pkg;

    localparam logic [7:0] OP_ARM  = 8'h41;  // 'A'
    localparam logic [7:0] OP_STOP = 8'h53;  // 'S'
    localparam logic [7:0] OP_MASK = 8'h4D;  // 'M'
    localparam logic [7:0] OP_DIV  = 8'h44;  // 'D'
    localparam logic [7:0] ACK_ERR = 8'h3F;  // '?'

    localparam int MASK_W = 3;
    localparam int DIV_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPERAND = 2'd1,
        ST_ACK     = 2'd2
    } state_e;

    function automatic logic op_known(input logic [7:0] op);
        return (op == OP_ARM) || (op == OP_STOP) || (op == OP_MASK) || (op == OP_DIV);
    endfunction

    function automatic logic [1:0] op_operands(input logic [7:0] op);
        case (op)
            OP_MASK: return 2'd1;
            OP_DIV:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Reloadable, saturating down-counter: expired asserts TIMEOUT_CYCLES enabled
// cycles after the last reload.
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Loading N-1 makes the zero count land exactly N cycles after the reload.
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload)
            cnt_d = LOAD;
        else if (enable && cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= LOAD;
        else
            cnt_q <= cnt_d;
    end

    assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_controller.sv
// Host-link command decoder driving trigger mask, sample divider and arm/abort.
// Define CMD_ECHO_EN to build the ACK state and the acknowledge byte handshake.
module uart_cmd_controller
    import la_cmd_pkg::*;
#(
    parameter int               TIMEOUT_CYCLES = 1_000_000,
    parameter logic [DIV_W-1:0] DIV_RESET      = 16'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              capture_busy,
    output logic [MASK_W-1:0] trig_mask,
    output logic [DIV_W-1:0]  sample_div,
    output logic              arm,
    output logic              abort,
    output logic              cmd_error,
    output logic [7:0]        ack_data,
    output logic              ack_valid,
    input  logic              ack_ready,
    output logic [1:0]        state_debug
);

    state_e            state_q;
    logic [7:0]        opcode_q;
    logic [7:0]        op_hi_q;
    logic [1:0]        remain_q;
    logic [MASK_W-1:0] mask_q;
    logic [DIV_W-1:0]  div_q;
    logic              arm_q, abort_q, err_q;
`ifdef CMD_ECHO_EN
    logic [7:0]        ack_data_q;
    logic              ack_valid_q;
`endif

    logic              byte_taken, timer_expired;
    logic [7:0]        fin_op, done_byte;
    logic [DIV_W-1:0]  div_val;
    logic              accept, final_byte, bad_op, timed_out, done, done_err;

    assign byte_taken = rx_valid && (state_q == ST_IDLE || state_q == ST_OPERAND);

    cmd_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .reload  (byte_taken),
        .enable  (state_q == ST_OPERAND),
        .expired (timer_expired)
    );

    // Completion is decided in the cycle of the final byte, using that cycle's busy.
    always_comb begin
        fin_op  = (state_q == ST_IDLE) ? rx_data : opcode_q;
        div_val = {op_hi_q, rx_data};
        case (fin_op)
            OP_STOP:         accept = 1'b1;
            OP_ARM, OP_MASK: accept = !capture_busy;
            OP_DIV:          accept = !capture_busy && (div_val != '0);
            default:         accept = 1'b0;
        endcase
        final_byte = rx_valid &&
                     ((state_q == ST_IDLE && op_known(rx_data) && op_operands(rx_data) == 2'd0) ||
                      (state_q == ST_OPERAND && remain_q == 2'd1));
        bad_op     = rx_valid && (state_q == ST_IDLE) && !op_known(rx_data);
        timed_out  = (state_q == ST_OPERAND) && !rx_valid && timer_expired;
        done       = final_byte || bad_op || timed_out;
        done_err   = bad_op || timed_out || (final_byte && !accept);
        done_byte  = done_err ? ACK_ERR : fin_op;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            opcode_q    <= 8'h00;
            op_hi_q     <= 8'h00;
            remain_q    <= 2'd0;
            mask_q      <= '1;
            div_q       <= DIV_RESET;
            arm_q       <= 1'b0;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef CMD_ECHO_EN
            ack_data_q  <= 8'h00;
            ack_valid_q <= 1'b0;
`endif
        end else begin
            arm_q   <= final_byte && accept && (fin_op == OP_ARM);
            abort_q <= final_byte && accept && (fin_op == OP_STOP);
            err_q   <= done_err;
            if (final_byte && accept && fin_op == OP_MASK)
                mask_q <= rx_data[MASK_W-1:0];
            if (final_byte && accept && fin_op == OP_DIV)
                div_q <= div_val;

            case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        opcode_q <= rx_data;
                        remain_q <= op_operands(rx_data);
                        if (op_known(rx_data) && op_operands(rx_data) != 2'd0)
                            state_q <= ST_OPERAND;
                    end
                end
                ST_OPERAND: begin
                    if (rx_valid) begin
                        op_hi_q  <= rx_data;
                        remain_q <= remain_q - 2'd1;
                    end
                end
                default: begin
`ifdef CMD_ECHO_EN
                    if (ack_valid_q && ack_ready)
                        state_q <= ST_IDLE;
`else
                    state_q <= ST_IDLE;
`endif
                end
            endcase

`ifdef CMD_ECHO_EN
            if (done) begin
                state_q     <= ST_ACK;
                ack_data_q  <= done_byte;
                ack_valid_q <= 1'b1;
            end else if (ack_valid_q && ack_ready) begin
                ack_valid_q <= 1'b0;
            end
`else
            if (done)
                state_q <= ST_IDLE;
`endif
        end
    end

    assign trig_mask   = mask_q;
    assign sample_div  = div_q;
    assign arm         = arm_q;
    assign abort       = abort_q;
    assign cmd_error   = err_q;
    assign state_debug = state_q;

`ifdef CMD_ECHO_EN
    assign ack_data  = ack_data_q;
    assign ack_valid = ack_valid_q;
`else
    logic [8:0] unused_ack;
    assign unused_ack = {ack_ready, done_byte};
    assign ack_data   = 8'h00;
    assign ack_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Bench for uart_cmd_controller: queue-based command model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_cmd_controller;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        capture_busy = 1'b0;
    logic        ack_ready = 1'b1;
    logic [2:0]  trig_mask;
    logic [15:0] sample_div;
    logic        arm, abort, cmd_error, ack_valid;
    logic [7:0]  ack_data;
    logic [1:0]  state_debug;

    always #5 clk = ~clk;

    uart_cmd_controller #(.TIMEOUT_CYCLES(T), .DIV_RESET(16'd1)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .capture_busy (capture_busy),
        .trig_mask    (trig_mask),
        .sample_div   (sample_div),
        .arm          (arm),
        .abort        (abort),
        .cmd_error    (cmd_error),
        .ack_data     (ack_data),
        .ack_valid    (ack_valid),
        .ack_ready    (ack_ready),
        .state_debug  (state_debug)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: bytes of the command in progress, idle cycles since the last byte,
    // and whether an acknowledge is still waiting for the transmit path.
    logic [7:0]  m_cmd[$];
    int          m_idle = 0;
    bit          m_live = 0;
    bit          m_ackp = 0;
    logic [7:0]  m_ackb = 8'h00;
    logic [2:0]  m_mask = 3'b111;
    logic [15:0] m_div = 16'd1;
    bit          m_arm = 0, m_abort = 0, m_err = 0;

    function automatic int need(input logic [7:0] op);
        case (op)
            8'h41, 8'h53: return 0;
            8'h4D:        return 1;
            8'h44:        return 2;
            default:      return -1;
        endcase
    endfunction

    task automatic model_finish(input bit err, input logic [7:0] op);
        m_err = err;
`ifdef CMD_ECHO_EN
        m_ackp = 1;
        m_ackb = err ? 8'h3F : op;
`else
        m_ackb = op;
`endif
        m_cmd.delete();
        m_idle = 0;
    endtask

    task automatic model_complete();
        logic [7:0]  op, b1, b2;
        logic [15:0] v;
        bit ok;
        op = m_cmd[0];
        ok = 0;
        case (op)
            8'h53: begin ok = 1; m_abort = 1; end
            8'h41: if (!capture_busy) begin ok = 1; m_arm = 1; end
            8'h4D: if (!capture_busy) begin ok = 1; b1 = m_cmd[1]; m_mask = b1[2:0]; end
            default: begin
                b1 = m_cmd[1];
                b2 = m_cmd[2];
                v = {b1, b2};
                if (!capture_busy && v != 16'd0) begin ok = 1; m_div = v; end
            end
        endcase
        model_finish(!ok, op);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_cmd.delete();
            m_idle = 0; m_ackp = 0; m_ackb = 8'h00;
            m_mask = 3'b111; m_div = 16'd1;
            m_arm = 0; m_abort = 0; m_err = 0;
            m_live = 1;
        end else if (m_live) begin
            m_arm = 0; m_abort = 0; m_err = 0;
            if (m_ackp) begin
                if (ack_ready) m_ackp = 0;
            end else if (rx_valid) begin
                m_cmd.push_back(rx_data);
                m_idle = 0;
                if (need(m_cmd[0]) < 0)
                    model_finish(1, m_cmd[0]);
                else if (m_cmd.size() == need(m_cmd[0]) + 1)
                    model_complete();
            end else if (m_cmd.size() > 0) begin
                m_idle++;
                if (m_idle >= T) model_finish(1, m_cmd[0]);
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("trig_mask", 32'(trig_mask), 32'(m_mask));
            chk("sample_div", 32'(sample_div), 32'(m_div));
            chk("arm", 32'(arm), 32'(m_arm));
            chk("abort", 32'(abort), 32'(m_abort));
            chk("cmd_error", 32'(cmd_error), 32'(m_err));
            chk("state_debug", 32'(state_debug), m_ackp ? 32'd2 : (m_cmd.size() > 0 ? 32'd1 : 32'd0));
`ifdef CMD_ECHO_EN
            chk("ack_valid", 32'(ack_valid), 32'(m_ackp));
            if (m_ackp) chk("ack_data", 32'(ack_data), 32'(m_ackb));
`else
            chk("ack_valid", 32'(ack_valid), 32'd0);
            chk("ack_data", 32'(ack_data), 32'd0);
`endif
        end
    end

    task automatic cyc(input bit v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = v ? d : 8'($urandom_range(0, 255));
        @(negedge clk);
    endtask

    localparam int NOPS = 5;
    logic [7:0] ops [NOPS] = '{8'h41, 8'h53, 8'h4D, 8'h44, 8'h00};

    initial begin
        // Reset state
        rst = 1; capture_busy = 0; ack_ready = 1;
        cyc(0, 0); cyc(0, 0);
        rst = 0;
        chk("rst trig_mask", 32'(trig_mask), 32'h7);
        chk("rst sample_div", 32'(sample_div), 32'h1);
        chk("rst strobes", 32'({arm, abort, cmd_error, ack_valid}), 32'h0);
        chk("rst state", 32'(state_debug), 32'h0);

        // 'D' 12 34 back to back; ack held while the transmit path stalls
        ack_ready = 0;
        cyc(1, 8'h44); cyc(1, 8'h12); cyc(1, 8'h34);
        chk("div 1234", 32'(sample_div), 32'h1234);
`ifdef CMD_ECHO_EN
        chk("div ack", 32'({ack_valid, ack_data}), 32'h144);
        cyc(0, 0); cyc(0, 0);
        chk("div ack held", 32'({ack_valid, ack_data}), 32'h144);
        ack_ready = 1;
        cyc(0, 0);
        chk("div ack done", 32'(ack_valid), 32'h0);
`endif
        ack_ready = 1;
        cyc(0, 0);

        // Mask rejected while busy, abort still accepted
        capture_busy = 1;
        cyc(1, 8'h4D); cyc(1, 8'h05);
        chk("busy mask err", 32'(cmd_error), 32'h1);
        chk("busy mask kept", 32'(trig_mask), 32'h7);
`ifdef CMD_ECHO_EN
        chk("busy mask ack", 32'(ack_data), 32'h3F);
`endif
        cyc(0, 0);
        chk("busy err once", 32'(cmd_error), 32'h0);
        cyc(1, 8'h53);
        chk("abort pulse", 32'(abort), 32'h1);
        cyc(0, 0);
        chk("abort once", 32'(abort), 32'h0);
        capture_busy = 0;
        cyc(0, 0);

        // Timeout after opcode with no operand
        cyc(1, 8'h4D);
        repeat (T - 1) cyc(0, 0);
        chk("timeout early", 32'(cmd_error), 32'h0);
        cyc(0, 0);
        chk("timeout err", 32'(cmd_error), 32'h1);
        cyc(0, 0); cyc(0, 0);
        chk("timeout idle", 32'(state_debug), 32'h0);

        // Operand on the expiry cycle is still taken
        cyc(1, 8'h4D);
        repeat (T - 1) cyc(0, 0);
        cyc(1, 8'h02);
        chk("expiry operand err", 32'(cmd_error), 32'h0);
        chk("expiry operand mask", 32'(trig_mask), 32'h2);
        cyc(0, 0); cyc(0, 0);

        // Unknown opcode, then zero divider
        cyc(1, 8'h7A);
        chk("unknown err", 32'(cmd_error), 32'h1);
`ifdef CMD_ECHO_EN
        chk("unknown ack", 32'(ack_data), 32'h3F);
`endif
        cyc(0, 0); cyc(0, 0);
        cyc(1, 8'h44); cyc(1, 8'h00); cyc(1, 8'h00);
        chk("div0 err", 32'(cmd_error), 32'h1);
        chk("div0 kept", 32'(sample_div), 32'h1234);
        cyc(0, 0); cyc(0, 0);

        // Reset in the middle of 'D', then arm
        cyc(1, 8'h44); cyc(1, 8'h12);
        rst = 1;
        cyc(0, 0);
        rst = 0;
        chk("midrst mask", 32'(trig_mask), 32'h7);
        chk("midrst div", 32'(sample_div), 32'h1);
        chk("midrst state", 32'(state_debug), 32'h0);
        cyc(1, 8'h41);
        chk("arm pulse", 32'(arm), 32'h1);
        cyc(0, 0);
        chk("arm once", 32'(arm), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 999) == 0);
            capture_busy = ($urandom_range(0, 3) == 0);
            ack_ready    = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 60) == 0) begin
                for (int k = 0; k < T + 3; k++) cyc(0, 0);
            end else if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 9) < 6)
                    cyc(1, ops[$urandom_range(0, NOPS - 1)]);
                else
                    cyc(1, 8'($urandom_range(0, 255)));
            end else begin
                cyc(0, 0);
            end
        end
        rst = 0; ack_ready = 1;
        repeat (T + 4) cyc(0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
